// File: rtl/tmds_pkg.sv
// Shared constants and state type for the TMDS lane framer.
package tmds_pkg;

  localparam int SYM_W     = 10;
  localparam int LANE_W    = 40;
  localparam int NUM_LANES = 4;

  localparam logic [SYM_W-1:0] CTRL_00     = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_01     = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_10     = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_11     = 10'b1010101011;
  localparam logic [SYM_W-1:0] CLK_PATTERN = 10'b0000011111;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

endpackage

// File: rtl/tmds_lane_expand.sv
// Replicates every symbol bit OVERSAMPLE times to fill one 40-bit GT lane.
module tmds_lane_expand
  import tmds_pkg::*;
#(
  parameter int OVERSAMPLE = 4,
  localparam int PPW = 4 / OVERSAMPLE
) (
  input  logic [PPW*SYM_W-1:0] sym_in,
  output logic [LANE_W-1:0]    lane_out
);

  always_comb begin
    lane_out = '0;
    for (int s = 0; s < PPW; s++) begin
      for (int b = 0; b < SYM_W; b++) begin
        for (int k = 0; k < OVERSAMPLE; k++) begin
          lane_out[s*SYM_W*OVERSAMPLE + b*OVERSAMPLE + k] = sym_in[s*SYM_W + b];
        end
      end
    end
  end

endmodule

// File: rtl/tmds_lane_framer.sv
// Frames TMDS pixels plus the TMDS clock pattern into a 4-lane GT TX word,
// with warm-up control tokens, underrun fill and per-lane polarity inversion.
//
// state     | meaning
// ----------|------------------------------------------------------------
// ST_OFF    | link idle, all lanes driven to zero (before inversion)
// ST_WARMUP | WARMUP_CYCLES words of CTRL_00 + clock pattern, no pixels taken
// ST_RUN    | pixels accepted; missing beats filled with CTRL_00
module tmds_lane_framer
  import tmds_pkg::*;
#(
  parameter int         OVERSAMPLE    = 4,
  parameter int         WARMUP_CYCLES = 1024,
  parameter logic [3:0] LANE_INVERT   = 4'b0000,
  localparam int PPW = 4 / OVERSAMPLE
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [PPW*30-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [159:0]           tx_data,
  output logic                   running,
  output logic                   underrun,
  output logic [15:0]            underrun_count,
  input  logic                   clear_status
);

  if (!(OVERSAMPLE == 1 || OVERSAMPLE == 2 || OVERSAMPLE == 4)) begin : g_bad_os
    $error("tmds_lane_framer: OVERSAMPLE must be 1, 2 or 4");
  end
  if (WARMUP_CYCLES < 1 || WARMUP_CYCLES > 65535) begin : g_bad_warmup
    $error("tmds_lane_framer: WARMUP_CYCLES must be 1..65535");
  end

  localparam logic [15:0] WARM_LOAD = 16'(WARMUP_CYCLES - 1);

  state_e         state_q, state_d;
  logic [15:0]    warm_cnt_q, warm_cnt_d;
  logic [159:0]   tx_data_q, tx_data_d;
  logic           underrun_q, underrun_d;
  logic [15:0]    underrun_count_q, underrun_count_d;

  logic           accept;
  logic           drive;
  logic           underrun_hit;
  logic [NUM_LANES-1:0][PPW*SYM_W-1:0] lane_sym;
  logic [NUM_LANES-1:0][LANE_W-1:0]    lane_exp;

  assign in_ready       = (state_q == ST_RUN) & enable;
  assign accept         = in_ready & in_valid;
  assign underrun_hit   = in_ready & ~in_valid;
  assign drive          = enable & (state_q != ST_OFF);
  assign running        = (state_q == ST_RUN);
  assign tx_data        = tx_data_q;
  assign underrun       = underrun_q;
  assign underrun_count = underrun_count_q;

  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    if (!enable) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d    = ST_WARMUP;
          warm_cnt_d = WARM_LOAD;
        end
        ST_WARMUP: begin
          if (warm_cnt_q == 16'd0) state_d = ST_RUN;
          else                     warm_cnt_d = warm_cnt_q - 16'd1;
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Data lanes fall back to CTRL_00 whenever no beat is taken this cycle.
  always_comb begin
    lane_sym = '0;
    for (int s = 0; s < PPW; s++) begin
      for (int c = 0; c < 3; c++) begin
        lane_sym[c][s*SYM_W +: SYM_W] = accept ? in_data[s*30 + c*SYM_W +: SYM_W] : CTRL_00;
      end
      lane_sym[3][s*SYM_W +: SYM_W] = CLK_PATTERN;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    tmds_lane_expand #(.OVERSAMPLE(OVERSAMPLE)) u_expand (
      .sym_in   (lane_sym[l]),
      .lane_out (lane_exp[l])
    );
  end

  always_comb begin
    tx_data_d = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      tx_data_d[l*LANE_W +: LANE_W] = (drive ? lane_exp[l] : '0) ^ {LANE_W{LANE_INVERT[l]}};
    end
  end

  // A clear coinciding with an underrun still counts that underrun word.
  always_comb begin
    underrun_d       = clear_status ? 1'b0  : underrun_q;
    underrun_count_d = clear_status ? 16'd0 : underrun_count_q;
    if (underrun_hit) begin
      underrun_d = 1'b1;
      if (underrun_count_d != 16'hFFFF) underrun_count_d = underrun_count_d + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_OFF;
      warm_cnt_q       <= '0;
      tx_data_q        <= '0;
      underrun_q       <= 1'b0;
      underrun_count_q <= '0;
    end else begin
      state_q          <= state_d;
      warm_cnt_q       <= warm_cnt_d;
      tx_data_q        <= tx_data_d;
      underrun_q       <= underrun_d;
      underrun_count_q <= underrun_count_d;
    end
  end

endmodule

// File: tb/tb_tmds_lane_framer.sv
// Self-checking bench: three framers (OS=4, OS=2 with lane inversion, OS=1)
// share control inputs and are checked against a word-level reference model.
module tb_tmds_lane_framer;

  localparam int W = 8;
  localparam logic [9:0] M_CTRL = 10'b1101010100;
  localparam logic [9:0] M_CLK  = 10'b0000011111;
  localparam logic [3:0] INV1   = 4'b1010;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         enable;
  logic         in_valid;
  logic         clear_status;
  logic [119:0] din;

  logic [159:0] tx0, tx1, tx2;
  logic         rdy0, rdy1, rdy2;
  logic         run0, run1, run2;
  logic         ur0, ur1, ur2;
  logic [15:0]  cnt0, cnt1, cnt2;

  int checks = 0;
  int errors = 0;

  // reference model: n = consecutive clock edges with enable high (saturating)
  int          n;
  logic        m_ur;
  logic [15:0] m_cnt;

  always #5 clock = ~clock;

  tmds_lane_framer #(.OVERSAMPLE(4), .WARMUP_CYCLES(W), .LANE_INVERT(4'b0000)) u_os4 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .in_data(din[29:0]),
    .in_valid(in_valid), .in_ready(rdy0), .tx_data(tx0), .running(run0),
    .underrun(ur0), .underrun_count(cnt0), .clear_status(clear_status));

  tmds_lane_framer #(.OVERSAMPLE(2), .WARMUP_CYCLES(W), .LANE_INVERT(INV1)) u_os2 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .in_data(din[59:0]),
    .in_valid(in_valid), .in_ready(rdy1), .tx_data(tx1), .running(run1),
    .underrun(ur1), .underrun_count(cnt1), .clear_status(clear_status));

  tmds_lane_framer #(.OVERSAMPLE(1), .WARMUP_CYCLES(W), .LANE_INVERT(4'b0000)) u_os1 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .in_data(din),
    .in_valid(in_valid), .in_ready(rdy2), .tx_data(tx2), .running(run2),
    .underrun(ur2), .underrun_count(cnt2), .clear_status(clear_status));

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Output bit i of a lane belongs to symbol i/(10*os), symbol bit (i mod 10*os)/os.
  function automatic logic [159:0] model_word(input int os, input logic [3:0] inv, input int nn,
                                              input logic en, input logic vld,
                                              input logic [119:0] data);
    logic [159:0] w;
    w = '0;
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 40; i++) begin
        int s;
        int b;
        logic [9:0] sym;
        logic bitv;
        s = i / (10 * os);
        b = (i % (10 * os)) / os;
        if (l == 3)                 sym = M_CLK;
        else if (nn > W && vld)     sym = data[30*s + 10*l +: 10];
        else                        sym = M_CTRL;
        bitv = (nn == 0 || !en) ? 1'b0 : sym[b];
        w[40*l + i] = bitv ^ inv[l];
      end
    end
    return w;
  endfunction

  task automatic step();
    logic [159:0] e0, e1, e2;
    logic exp_rdy;
    @(negedge clock);
    exp_rdy = (n > W) && enable;
    chk("in_ready_os4", 160'(rdy0), 160'(exp_rdy));
    chk("in_ready_os2", 160'(rdy1), 160'(exp_rdy));
    chk("in_ready_os1", 160'(rdy2), 160'(exp_rdy));
    e0 = model_word(4, 4'b0000, n, enable, in_valid, din);
    e1 = model_word(2, INV1,    n, enable, in_valid, din);
    e2 = model_word(1, 4'b0000, n, enable, in_valid, din);
    if (clear_status) begin
      m_ur  = 1'b0;
      m_cnt = 16'd0;
    end
    if (exp_rdy && !in_valid) begin
      m_ur = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    @(posedge clock);
    #1;
    n = enable ? ((n > W) ? W + 1 : n + 1) : 0;
    chk("tx_os4", tx0, e0);
    chk("tx_os2", tx1, e1);
    chk("tx_os1", tx2, e2);
    chk("running", 160'({run0, run1, run2}), 160'({3{n > W}}));
    chk("underrun", 160'({ur0, ur1, ur2}), 160'({3{m_ur}}));
    chk("underrun_count", 160'({cnt0, cnt1, cnt2}), 160'({3{m_cnt}}));
  endtask

  // Steps with enable high until in_ready appears; returns the edge count.
  task automatic count_to_ready(output int cyc);
    cyc = 0;
    while (cyc < 40) begin
      step();
      cyc++;
      if (cyc == 2) begin
        chk("warmup_lane0_ctrl", 160'(tx0[39:0]), 160'(40'hFF0F0F0F00));
        chk("warmup_lane3_clk",  160'(tx0[159:120]), 160'(40'h00000FFFFF));
      end
      if (rdy0) break;
    end
  endtask

  typedef struct {
    int            inst;
    logic [119:0]  data;
    logic [39:0]   l0;
    logic [39:0]   l1;
    logic [39:0]   l2;
  } row_t;

  row_t rows[5];

  initial begin
    int cyc;
    logic [127:0] r;
    logic [159:0] t;

    rows[0] = '{0, 120'({10'h3FF, 10'h000, 10'h155}),
                40'h0F0F0F0F0F, 40'h0000000000, 40'hFFFFFFFFFF};
    rows[1] = '{1, 120'({2{10'h3FF, 10'h000, 10'h155}}),
                40'h3333333333, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF};
    rows[2] = '{2, 120'({30'h8, 30'h4, 30'h2, 30'h1}),
                40'h0200400801, 40'h0000000000, 40'h0000000000};
    rows[3] = '{0, 120'({10'h000, 10'h3FF, 10'h001}),
                40'h000000000F, 40'hFFFFFFFFFF, 40'h0000000000};
    rows[4] = '{1, 120'({30'h200, 30'h001}),
                40'hC000000003, 40'hFFFFFFFFFF, 40'h0000000000};

    reset_n = 1'b0; enable = 1'b0; in_valid = 1'b0; clear_status = 1'b0; din = '0;
    n = 0; m_ur = 1'b0; m_cnt = 16'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_tx", tx0 | tx1 | tx2, 160'd0);
    chk("reset_ready", 160'({rdy0, rdy1, rdy2}), 160'd0);
    chk("reset_running", 160'({run0, run1, run2}), 160'd0);
    chk("reset_status", 160'({ur0, cnt0, ur1, cnt1, ur2, cnt2}), 160'd0);
    #1 reset_n = 1'b1;

    // enable -> warm-up, first in_ready after W+1 edges
    enable = 1'b1; in_valid = 1'b1;
    count_to_ready(cyc);
    chk("warmup_length", 160'(cyc), 160'(W + 1));

    foreach (rows[i]) begin
      din = rows[i].data;
      in_valid = 1'b1;
      step();
      t = (rows[i].inst == 0) ? tx0 : (rows[i].inst == 1) ? tx1 : tx2;
      chk($sformatf("vec%0d_lane0", i), 160'(t[39:0]),  160'(rows[i].l0));
      chk($sformatf("vec%0d_lane1", i), 160'(t[79:40]), 160'(rows[i].l1));
      chk($sformatf("vec%0d_lane2", i), 160'(t[119:80]), 160'(rows[i].l2));
    end

    for (int k = 0; k < 400; k++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      din = r[119:0];
      in_valid = ($urandom_range(0, 9) != 0);
      clear_status = ($urandom_range(0, 19) == 0);
      enable = ($urandom_range(0, 99) != 0);
      step();
    end

    enable = 1'b1; in_valid = 1'b1; clear_status = 1'b0;
    repeat (12) step();

    // three underrun words, then clear behaviour
    clear_status = 1'b1;
    step();
    clear_status = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("underrun_lane0_ctrl", 160'(tx0[39:0]), 160'(40'hFF0F0F0F00));
      chk("underrun_lane3_clk",  160'(tx0[159:120]), 160'(40'h00000FFFFF));
    end
    chk("underrun_3", 160'({ur0, cnt0}), 160'({1'b1, 16'd3}));
    in_valid = 1'b1; clear_status = 1'b1;
    step();
    chk("clear_status", 160'({ur0, cnt0}), 160'({1'b0, 16'd0}));
    in_valid = 1'b0;
    step();
    chk("clear_with_underrun", 160'({ur0, cnt0}), 160'({1'b1, 16'd1}));

    clear_status = 1'b0;
    repeat (65540) step();
    chk("count_saturate", 160'(cnt0), 160'(16'hFFFF));
    clear_status = 1'b1; in_valid = 1'b1;
    step();
    clear_status = 1'b0;

    // enable drop: next word idle (inverted lanes all ones)
    enable = 1'b0;
    step();
    chk("disable_tx_os4", tx0, 160'd0);
    chk("disable_tx_os2", tx1, {40'hFFFFFFFFFF, 40'h0, 40'hFFFFFFFFFF, 40'h0});
    chk("disable_ready", 160'(rdy0), 160'd0);
    enable = 1'b1;
    count_to_ready(cyc);
    chk("rewarmup_length", 160'(cyc), 160'(W + 1));
    repeat (3) step();

    // asynchronous reset between edges
    #2 reset_n = 1'b0; enable = 1'b0;
    #1;
    chk("async_reset_tx", tx0 | tx1 | tx2, 160'd0);
    chk("async_reset_running", 160'({run0, rdy0, ur0, cnt0}), 160'd0);
    n = 0; m_ur = 1'b0; m_cnt = 16'd0;
    #1 reset_n = 1'b1;
    step();
    chk("after_reset_off_os2", tx1, {40'hFFFFFFFFFF, 40'h0, 40'hFFFFFFFFFF, 40'h0});
    enable = 1'b1;
    count_to_ready(cyc);
    chk("post_reset_warmup", 160'(cyc), 160'(W + 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
